// File: rtl/expr_pipe_pkg.sv
// expr_pipe_pkg: shared definitions for the pipelined lane-parallel expression
// evaluator. Holds the opcode encoding, the opcode width and the helper that
// gives the shift amount at which shifts saturate.
package expr_pipe_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_XNOR = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_LT   = 4'd8,
    OP_LE   = 4'd9,
    OP_EQ   = 4'd10,
    OP_NE   = 4'd11,
    OP_RAND = 4'd12,
    OP_ROR  = 4'd13,
    OP_RXOR = 4'd14,
    OP_MUL  = 4'd15
  } op_e;

  // Any shift amount at or above this value moves every operand bit out of
  // the lane, so the result takes its saturated value.
  function automatic int shiftLimit(input int laneWidth);
    return laneWidth;
  endfunction

endpackage

// File: rtl/expr_pipe_eval_lane.sv
// expr_lane: purely combinational single-lane ALU.
// Ports:
//   op_i     - opcode (op_e)
//   signed_i - 1 = operands are two's-complement, 0 = unsigned
//   a_i, b_i - W-bit operands
//   y_o      - W-bit result (truncated)
//   flag_o   - per-op flag (carry/borrow/overflow, shifted-out, compare, ...)
module expr_lane
  import expr_pipe_pkg::*;
#(
  parameter int W = 6
) (
  input  op_e          op_i,
  input  logic         signed_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o,
  output logic         flag_o
);

  localparam int           SHIFT_LIM   = shiftLimit(W);
  localparam logic [W-1:0] SHIFT_LIM_V = SHIFT_LIM[W-1:0];

  logic [W:0]          sum;
  logic [W:0]          diff;
  logic [2*W-1:0]      shlWide;
  logic [2*W-1:0]      aExt;
  logic [2*W-1:0]      bExt;
  logic [2*W-1:0]      prod;
  logic signed [W-1:0] aSigned;
  logic                shiftSat;
  logic                lt;
  logic                eq;

  always_comb begin
    sum      = {1'b0, a_i} + {1'b0, b_i};
    diff     = {1'b0, a_i} - {1'b0, b_i};
    shiftSat = (b_i >= SHIFT_LIM_V);
    // Shifting into a double-width word keeps the bits that fall off the
    // top of the lane so the SHL flag can see them.
    shlWide  = {{W{1'b0}}, a_i} << b_i;
    aSigned  = a_i;
    // Sign- or zero-extending to 2W makes one unsigned multiplier give the
    // correct full product for either signedness.
    aExt     = signed_i ? {{W{a_i[W-1]}}, a_i} : {{W{1'b0}}, a_i};
    bExt     = signed_i ? {{W{b_i[W-1]}}, b_i} : {{W{1'b0}}, b_i};
    prod     = aExt * bExt;
    eq       = (a_i == b_i);
    lt       = signed_i ? ($signed(a_i) < $signed(b_i)) : (a_i < b_i);

    y_o    = '0;
    flag_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        y_o    = sum[W-1:0];
        flag_o = signed_i ? ((a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]))
                          : sum[W];
      end
      OP_SUB: begin
        y_o    = diff[W-1:0];
        flag_o = signed_i ? ((a_i[W-1] != b_i[W-1]) && (diff[W-1] != a_i[W-1]))
                          : diff[W];
      end
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_XNOR: y_o = ~(a_i ^ b_i);
      OP_SHL: begin
        if (shiftSat) begin
          y_o    = '0;
          flag_o = |a_i;
        end else begin
          y_o    = shlWide[W-1:0];
          flag_o = |shlWide[2*W-1:W];
        end
      end
      OP_SHR: begin
        if (shiftSat) begin
          y_o = signed_i ? {W{a_i[W-1]}} : '0;
        end else if (signed_i) begin
          y_o = aSigned >>> b_i;
        end else begin
          y_o = a_i >> b_i;
        end
      end
      OP_LT: begin
        y_o[0] = lt;
        flag_o = lt;
      end
      OP_LE: begin
        y_o[0] = lt | eq;
        flag_o = lt | eq;
      end
      OP_EQ: begin
        y_o[0] = eq;
        flag_o = eq;
      end
      OP_NE: begin
        y_o[0] = ~eq;
        flag_o = ~eq;
      end
      OP_RAND: begin
        y_o[0] = &a_i;
        flag_o = &a_i;
      end
      OP_ROR: begin
        y_o[0] = |a_i;
        flag_o = |a_i;
      end
      OP_RXOR: begin
        y_o[0] = ^a_i;
        flag_o = ^a_i;
      end
      OP_MUL: begin
        y_o    = prod[W-1:0];
        // Signed results fit only if the upper half is a pure sign extension.
        flag_o = signed_i ? (prod[2*W-1:W] != {W{prod[W-1]}})
                          : (|prod[2*W-1:W]);
      end
      default: begin
        y_o    = '0;
        flag_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/expr_pipe_eval.sv
// expr_pipe_eval: two-stage pipelined, valid/ready handshaked evaluator that
// applies one opcode to LANES independent operand pairs per transaction.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid / in_ready  - input handshake
//   in_op, in_signed     - opcode and signedness for all lanes
//   in_a, in_b           - packed operands, lane i at [i*W +: W]
//   out_valid / out_ready- output handshake
//   out_y, out_flag      - packed per-lane results and flags
//   out_seq              - sequence tag of the presented result
module expr_pipe_eval
  import expr_pipe_pkg::*;
#(
  parameter int LANES = 6,
  parameter int W     = 6,
  parameter int SEQ_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_op,
  input  logic               in_signed,
  input  logic [LANES*W-1:0] in_a,
  input  logic [LANES*W-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_y,
  output logic [LANES-1:0]   out_flag,
  output logic [SEQ_W-1:0]   out_seq
);

  // S1: captured operands and opcode
  logic               s1Valid_q, s1Valid_d;
  op_e                s1Op_q, s1Op_d;
  logic               s1Signed_q, s1Signed_d;
  logic [LANES*W-1:0] s1A_q, s1A_d;
  logic [LANES*W-1:0] s1B_q, s1B_d;

  // S2: registered results plus the running sequence counter
  logic               s2Valid_q, s2Valid_d;
  logic [LANES*W-1:0] s2Y_q, s2Y_d;
  logic [LANES-1:0]   s2Flag_q, s2Flag_d;
  logic [SEQ_W-1:0]   s2Seq_q, s2Seq_d;
  logic [SEQ_W-1:0]   seqCnt_q, seqCnt_d;

  logic [LANES*W-1:0] laneY;
  logic [LANES-1:0]   laneFlag;
  logic               adv2;

  for (genvar g = 0; g < LANES; g++) begin : gLane
    expr_lane #(.W(W)) uLane (
      .op_i    (s1Op_q),
      .signed_i(s1Signed_q),
      .a_i     (s1A_q[g*W +: W]),
      .b_i     (s1B_q[g*W +: W]),
      .y_o     (laneY[g*W +: W]),
      .flag_o  (laneFlag[g])
    );
  end

  // S2 can take new data when it is empty or its result is being consumed;
  // S1 can take new data when it is empty or can hand off to S2.
  assign adv2     = ~s2Valid_q | out_ready;
  assign in_ready = ~s1Valid_q | adv2;

  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1Op_d     = s1Op_q;
    s1Signed_d = s1Signed_q;
    s1A_d      = s1A_q;
    s1B_d      = s1B_q;
    s2Valid_d  = s2Valid_q;
    s2Y_d      = s2Y_q;
    s2Flag_d   = s2Flag_q;
    s2Seq_d    = s2Seq_q;
    seqCnt_d   = seqCnt_q;

    if (in_ready) begin
      s1Valid_d = in_valid;
      if (in_valid) begin
        s1Op_d     = op_e'(in_op);
        s1Signed_d = in_signed;
        s1A_d      = in_a;
        s1B_d      = in_b;
      end
    end

    if (adv2) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        s2Y_d    = laneY;
        s2Flag_d = laneFlag;
        s2Seq_d  = seqCnt_q;
        seqCnt_d = seqCnt_q + SEQ_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q  <= 1'b0;
      s1Op_q     <= OP_ADD;
      s1Signed_q <= 1'b0;
      s1A_q      <= '0;
      s1B_q      <= '0;
      s2Valid_q  <= 1'b0;
      s2Y_q      <= '0;
      s2Flag_q   <= '0;
      s2Seq_q    <= '0;
      seqCnt_q   <= '0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Op_q     <= s1Op_d;
      s1Signed_q <= s1Signed_d;
      s1A_q      <= s1A_d;
      s1B_q      <= s1B_d;
      s2Valid_q  <= s2Valid_d;
      s2Y_q      <= s2Y_d;
      s2Flag_q   <= s2Flag_d;
      s2Seq_q    <= s2Seq_d;
      seqCnt_q   <= seqCnt_d;
    end
  end

  assign out_valid = s2Valid_q;
  assign out_y     = s2Y_q;
  assign out_flag  = s2Flag_q;
  assign out_seq   = s2Seq_q;

endmodule
